inst_fetch: RTL and testbench
=============================

# inst_fetch

Sequencer that reads the 64-deep, 39-bit instruction queue in order from address 0 and issues each word downstream. It drives the queue's `memread`/`address` inputs, registers the combinational `readdata`, splits the word into opcode and operand fields, and presents them on a valid/ready handshake to the execution stage. Fetch stops on an all-zero (empty) slot, on reaching `LAST_ADDR`, or on `abort`.

## Interface
- `LAST_ADDR`, 63: final queue address fetched. Range 0..63.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a run from address 0. Ignored unless in IDLE or DONE.
- `abort`  in  1  ends the run; the next state is DONE.
- `memread`  out  1  read enable to the instruction queue.
- `address`  out  6  queue address.
- `readdata`  in  39  instruction word from the queue. Combinational, valid in the same cycle as `memread`.
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  the execution stage accepts the instruction.
- `opcode`  out  3  `word[38:36]`
- `field_a`  out  4  `word[35:32]`
- `field_b`  out  4  `word[31:28]`
- `imm`  out  32  `word[31:0]`
- `busy`  out  1  high in FETCH or ISSUE.
- `done`  out  1  high in DONE.
- `issued`  out  7  count of handshakes in the current run. Range 0..64.

## Operation
- Reset (`rst_n`=0 at a rising edge):
  - state moves to IDLE;
  - `pc`, `address`, `issued` = 0;
  - `memread`, `out_valid`, `busy`, `done` = 0;
  - the instruction register = 0, so `opcode`/`field_a`/`field_b`/`imm` read 0.
- States: IDLE, FETCH, ISSUE, DONE.
- **IDLE**
  - `start` → FETCH.
  - On this transition: `pc` = 0 and `issued` = 0.
- **FETCH**
  - `memread` = 1 and `address` = `pc` for exactly one cycle.
  - At the end of the cycle, `readdata` is latched into the instruction register.
  - If `readdata` == 0 → DONE. The empty slot is not issued.
  - Otherwise → ISSUE.
- **ISSUE**
  - `out_valid` = 1 and `memread` = 0.
  - Fields are decoded from the register and stay stable until the handshake.
  - Handshake = `out_valid` & `out_ready` at a rising edge. On handshake, `issued` += 1.
  - If `pc` == `LAST_ADDR` → DONE. Otherwise `pc` += 1 and → FETCH.
- **DONE**
  - `done` = 1.
  - The instruction register holds the last word fetched.
  - `start` → FETCH, with a fresh run (`pc` and `issued` cleared).
- **abort**
  - In FETCH or ISSUE → DONE at the next edge. No handshake completes in that cycle, even if `out_ready` = 1.
  - In IDLE or DONE it has no effect.
  - `start` and `abort` in the same cycle: `abort` wins in FETCH/ISSUE. In IDLE/DONE, `start` is taken.
- Width rules:
  - `pc` is 6 bits and never wraps, because `LAST_ADDR` bounds it.
  - `issued` is 7 bits so that 64 fits.
- `address` holds `pc` at all times. `memread` is the only read qualifier.

## Timing
- `start` sampled at edge N → FETCH occupies cycle N..N+1 → `out_valid` rises after edge N+1.
- Fetch-to-issue latency is 1 cycle.
- Sustained rate is 1 instruction per 2 cycles when `out_ready` is held high.
- `out_valid`, once asserted, stays high until the handshake or `abort`. Fields do not change while it is high.
- `done` rises the edge after the terminating FETCH, handshake or `abort`.
- Reset mid-run takes effect at the next edge. No partial handshake occurs and all outputs take their reset values.
- All outputs are registered except `memread` and `address`, which are decoded directly from state and `pc`.

## Test plan
- **Program of 41 words (0..40), slot 41 = 0, `out_ready`=1, single `start`:**
  - 41 handshakes: opcodes 000, 001×10, 010×10, 011×10, 110×10.
  - Slot 0 issues opcode 000, `field_a`=1, `imm`=1.
  - Slot 21 issues `field_a`=1, `field_b`=1, `imm`=0x1000_0000.
  - Then 1 FETCH of address 41 follows, then `done`=1 with `issued`=41.
  - `start`→`done` takes 84 cycles.
- **Backpressure:** `out_ready` low for 5 cycles at slot 3.
  - `out_valid` stays 1 with `imm`=3 stable and `memread`=0 throughout.
  - Slot 4 is fetched 1 cycle after `out_ready` rises.
- **`LAST_ADDR`=2, all slots nonzero:**
  - Exactly 3 issues (addresses 0, 1, 2).
  - `address` never reaches 3; `issued`=3; `done`=1.
- **`abort` at slot 5 with `out_ready`=1 in the same cycle:**
  - No handshake; `issued`=5; `done`=1 next cycle.
  - A following `start` restarts at address 0 with `issued`=0.
- **`rst_n`=0 for 1 cycle while in ISSUE at slot 7:** all outputs go to 0, state returns to IDLE, and `start` is ignored during reset.
- **Full 64 nonzero slots with `LAST_ADDR`=63:** `issued`=64 with no wrap to address 0.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Bundle of the instruction-queue read port and the downstream issue handshake.
// master: the fetch sequencer. slave: queue plus execution stage.
interface inst_fetch_if;
  logic        memread;
  logic [5:0]  address;
  logic [38:0] readdata;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  opcode;
  logic [3:0]  field_a;
  logic [3:0]  field_b;
  logic [31:0] imm;

  modport master (
    output memread, address, out_valid, opcode, field_a, field_b, imm,
    input  readdata, out_ready
  );

  modport slave (
    input  memread, address, out_valid, opcode, field_a, field_b, imm,
    output readdata, out_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: walks the 64-deep instruction queue from
// address 0, registers each word and offers it on a valid/ready handshake.
// A run ends on an all-zero slot, after LAST_ADDR is issued, or on abort.
module inst_fetch #(
  parameter int unsigned LAST_ADDR = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  inst_fetch_if.master bus,
  output logic         busy,
  output logic         done,
  output logic [6:0]   issued
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [5:0] LAST = 6'(LAST_ADDR);

  state_t      state;
  logic [5:0]  pc;
  logic [38:0] ir;
  logic        out_valid;

  // Queue read port is decoded straight from state and pc; memread alone qualifies the read.
  assign bus.memread = (state == FETCH);
  assign bus.address = pc;

  // Issue fields are fixed slices of the instruction register.
  assign bus.out_valid = out_valid;
  assign bus.opcode    = ir[38:36];
  assign bus.field_a   = ir[35:32];
  assign bus.field_b   = ir[31:28];
  assign bus.imm       = ir[31:0];

  // Sequencer FSM with registered status and handshake outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      // NOTE: ir is a single register, so it is reset; fields read 0 after reset.
      ir        <= '0;
      issued    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= FETCH;
            pc     <= '0;
            issued <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end

        FETCH: begin
          if (abort) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ir <= bus.readdata;
            if (bus.readdata == '0) begin
              // Empty slot terminates the run without being issued.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              out_valid <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (abort) begin
            // Abort beats a simultaneous out_ready: no handshake this edge.
            state     <= DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (bus.out_ready) begin
            issued    <= issued + 7'd1;
            out_valid <= 1'b0;
            if (pc == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 6'd1;
              state <= FETCH;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. Two instances share one instruction
// queue image: dut_a with LAST_ADDR=63 and dut_b with LAST_ADDR=2. A
// transaction-level model predicts every output each cycle; directed runs
// pin the model with hand-computed values, then a random phase follows.
module tb_inst_fetch;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic out_ready;

  logic [38:0] mem [64];

  inst_fetch_if bus_a ();
  inst_fetch_if bus_b ();

  logic       busy_a, done_a, busy_b, done_b;
  logic [6:0] issued_a, issued_b;

  assign bus_a.readdata  = mem[bus_a.address];
  assign bus_b.readdata  = mem[bus_b.address];
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  inst_fetch #(.LAST_ADDR(63)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(bus_a), .busy(busy_a), .done(done_a), .issued(issued_a)
  );

  inst_fetch #(.LAST_ADDR(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(bus_b), .busy(busy_b), .done(done_b), .issued(issued_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A run is either fetching the slot at pc or holding a word for issue.
  typedef struct {
    bit        run;
    bit        fetching;
    bit [5:0]  pc;
    bit [38:0] word;
    bit [6:0]  issued;
    bit        done;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(input model_t m, input int last);
    model_t n = m;
    if (!rst_n) begin
      n = '{default: 0};
    end else if (!m.run) begin
      if (start) begin
        n.run = 1; n.fetching = 1; n.pc = 0; n.issued = 0; n.done = 0;
      end
    end else if (abort) begin
      n.run = 0; n.done = 1;
    end else if (m.fetching) begin
      n.word = mem[m.pc];
      if (mem[m.pc] == 0) begin
        n.run = 0; n.done = 1;
      end else begin
        n.fetching = 0;
      end
    end else if (out_ready) begin
      n.issued = m.issued + 1;
      if (int'(m.pc) == last) begin
        n.run = 0; n.done = 1;
      end else begin
        n.pc = m.pc + 1; n.fetching = 1;
      end
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input model_t m,
                     input logic mr, input logic [5:0] ad, input logic ov,
                     input logic [2:0] op, input logic [3:0] fa, input logic [3:0] fb,
                     input logic [31:0] im, input logic bz, input logic dn,
                     input logic [6:0] is);
    check({tag, ".memread"},   mr, m.run & m.fetching);
    check({tag, ".address"},   ad, m.pc);
    check({tag, ".out_valid"}, ov, m.run & ~m.fetching);
    check({tag, ".opcode"},    op, m.word[38:36]);
    check({tag, ".field_a"},   fa, m.word[35:32]);
    check({tag, ".field_b"},   fb, m.word[31:28]);
    check({tag, ".imm"},       im, m.word[31:0]);
    check({tag, ".busy"},      bz, m.run);
    check({tag, ".done"},      dn, m.done);
    check({tag, ".issued"},    is, m.issued);
  endtask

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  field_a;
    logic [3:0]  field_b;
    logic [31:0] imm;
  } hs_t;

  hs_t hs_log[$];
  int  max_addr_b = 0;

  // Advance the model on every edge, log dut_a handshakes, then compare.
  always @(posedge clk) begin
    if (rst_n && !abort && bus_a.out_valid && out_ready)
      hs_log.push_back('{bus_a.opcode, bus_a.field_a, bus_a.field_b, bus_a.imm});
    ma = step(ma, 63);
    mb = step(mb, 2);
    #1;
    cmp("a", ma, bus_a.memread, bus_a.address, bus_a.out_valid, bus_a.opcode,
        bus_a.field_a, bus_a.field_b, bus_a.imm, busy_a, done_a, issued_a);
    cmp("b", mb, bus_b.memread, bus_b.address, bus_b.out_valid, bus_b.opcode,
        bus_b.field_a, bus_b.field_b, bus_b.imm, busy_b, done_b, issued_b);
    if (bus_b.memread && int'(bus_b.address) > max_addr_b)
      max_addr_b = int'(bus_b.address);
  end

  // ------------------------------------------------------------- stimulus
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for dut_a to present address a in FETCH (fetch=1) or ISSUE (fetch=0).
  task automatic wait_slot(input string name, input bit fetch, input logic [5:0] a);
    int n = 0;
    while (!((fetch ? bus_a.memread : bus_a.out_valid) && bus_a.address == a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check({name, ".timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!done_a && cycles < 600) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 600) check({name, ".timeout"}, 0, 1);
  endtask

  initial begin
    int cycles;
    int opc [8];
    logic [38:0] w;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("reset.busy",      busy_a, 0);
    check("reset.done",      done_a, 0);
    check("reset.issued",    issued_a, 0);
    check("reset.out_valid", bus_a.out_valid, 0);
    check("reset.memread",   bus_a.memread, 0);
    check("reset.imm",       bus_a.imm, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Program: slot 0 op 0, then ten each of opcodes 1, 2, 3, 6; slot 41 empty.
    for (int i = 0; i <= 40; i++) begin
      logic [2:0]  op;
      logic [31:0] im;
      op = (i == 0) ? 3'd0 : (i <= 10) ? 3'd1 : (i <= 20) ? 3'd2 : (i <= 30) ? 3'd3 : 3'd6;
      im = (i == 0) ? 32'd1 : (i == 21) ? 32'h1000_0000 : 32'(i);
      mem[i] = {op, 4'h1, im};
    end
    for (int i = 42; i < 64; i++) mem[i] = {3'd5, 4'h2, 32'(i)};

    // Run 1: free-flowing, single start; dut_b stops after address 2.
    out_ready = 1'b1;
    hs_log.delete();
    pulse_start();
    wait_done("run1", cycles);
    check("run1.start_to_done_cycles", cycles + 1, 84);
    check("run1.issued_a", issued_a, 41);
    check("run1.last_fetch_addr", bus_a.address, 41);
    check("run1.issued_b", issued_b, 3);
    check("run1.done_b", done_b, 1);
    check("run1.max_addr_b", max_addr_b, 2);
    check("run1.hs_count", hs_log.size(), 41);
    for (int k = 0; k < 8; k++) opc[k] = 0;
    foreach (hs_log[k]) opc[hs_log[k].opcode]++;
    check("run1.op0", opc[0], 1);
    check("run1.op1", opc[1], 10);
    check("run1.op2", opc[2], 10);
    check("run1.op3", opc[3], 10);
    check("run1.op6", opc[6], 10);
    if (hs_log.size() == 41) begin
      check("run1.slot0.opcode",  hs_log[0].opcode, 0);
      check("run1.slot0.field_a", hs_log[0].field_a, 1);
      check("run1.slot0.imm",     hs_log[0].imm, 1);
      check("run1.slot21.field_a", hs_log[21].field_a, 1);
      check("run1.slot21.field_b", hs_log[21].field_b, 1);
      check("run1.slot21.imm",     hs_log[21].imm, 32'h1000_0000);
    end

    // Run 2: five cycles of backpressure while slot 3 is offered.
    pulse_start();
    wait_slot("bp", 0, 6'd3);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp.out_valid", bus_a.out_valid, 1);
      check("bp.imm",       bus_a.imm, 3);
      check("bp.memread",   bus_a.memread, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.slot4_memread", bus_a.memread, 1);
    check("bp.slot4_address", bus_a.address, 4);
    wait_done("run2", cycles);
    check("run2.issued_a", issued_a, 41);

    // Run 3: abort while slot 5 is offered and out_ready is high.
    pulse_start();
    wait_slot("abort", 1, 6'd5);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.done",      done_a, 1);
    check("abort.issued",    issued_a, 5);
    check("abort.out_valid", bus_a.out_valid, 0);
    pulse_start();
    check("restart.address", bus_a.address, 0);
    check("restart.issued",  issued_a, 0);
    check("restart.memread", bus_a.memread, 1);

    // Reset for one cycle while slot 7 is offered; start is held meanwhile.
    wait_slot("rst", 0, 6'd7);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("midrst.busy",      busy_a, 0);
    check("midrst.done",      done_a, 0);
    check("midrst.out_valid", bus_a.out_valid, 0);
    check("midrst.issued",    issued_a, 0);
    check("midrst.address",   bus_a.address, 0);
    check("midrst.opcode",    bus_a.opcode, 0);
    check("midrst.imm",       bus_a.imm, 0);
    @(negedge clk);
    check("midrst.idle_busy",    busy_a, 0);
    check("midrst.idle_memread", bus_a.memread, 0);

    // Run 4: all 64 slots nonzero, so only LAST_ADDR ends the run.
    for (int i = 0; i < 64; i++) begin
      w = {7'($urandom), 32'($urandom)};
      mem[i] = (w == 0) ? 39'd1 : w;
    end
    pulse_start();
    wait_done("full", cycles);
    check("full.issued",  issued_a, 64);
    check("full.address", bus_a.address, 63);

    // Random phase: random ready, rare abort/start/reset, queue rewritten on the fly.
    for (int c = 0; c < 3000; c++) begin
      int s;
      out_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 80) == 0);
      start     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 500) != 0);
      s = $urandom_range(0, 63);
      mem[s] = ($urandom_range(0, 20) == 0) ? 39'd0 : {7'($urandom), 32'($urandom)};
      @(negedge clk);
    end

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
